chroma_key_mixer: RTL and testbench

- Upstream neighbour of the VGA output stage; turns the camera stream into composited pixels.
- Buffers camera pixels and their matching background pixels in a small FIFO.
- Replaces green-screen (key) pixels with the background pixel.
- Returns one composited RGB pixel per VGA request, exactly 2 clocks after the request, matching the VGA stage's 2-cycle early request.

---
 rtl/chroma_key_mixer_if.sv | 30 +++
 rtl/chroma_key_mixer.sv | 154 +++++++++++++++
 tb/tb_chroma_key_mixer.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/chroma_key_mixer_if.sv
// Camera/background beat input and VGA request/pixel output bundle for chroma_key_mixer.
// The slave modport is the mixer's view; master is the view of whatever drives it.
interface chroma_key_mixer_if;
  logic       inCamValid;
  logic       outCamReady;
  logic       inCamSof;
  logic [9:0] inCamR;
  logic [9:0] inCamG;
  logic [9:0] inCamB;
  logic [9:0] inBgR;
  logic [9:0] inBgG;
  logic [9:0] inBgB;
  logic       inRequest;
  logic [9:0] outRed;
  logic [9:0] outGreen;
  logic [9:0] outBlue;
  logic       outPixValid;
  logic       outUnderflow;
  logic [1:0] outState;

  modport slave (
    input  inCamValid, inCamSof, inCamR, inCamG, inCamB, inBgR, inBgG, inBgB, inRequest,
    output outCamReady, outRed, outGreen, outBlue, outPixValid, outUnderflow, outState
  );

  modport master (
    output inCamValid, inCamSof, inCamR, inCamG, inCamB, inBgR, inBgG, inBgB, inRequest,
    input  outCamReady, outRed, outGreen, outBlue, outPixValid, outUnderflow, outState
  );
endinterface

// File: rtl/chroma_key_mixer.sv
// Buffers camera+background beats and returns one chroma-keyed pixel per VGA request, 2 clocks later.
// Define CHROMA_KEY_DEBUG_EN to paint key pixels magenta instead of showing the background.
module chroma_key_mixer #(
  parameter int         FIFO_DEPTH = 16,
  parameter int         FILL_LEVEL = 8,
  parameter logic [9:0] KEY_G_MIN  = 10'd400,
  parameter logic [9:0] KEY_MARGIN = 10'd96
) (
  input  logic                 iCLK,
  input  logic                 iRST,
  chroma_key_mixer_if.slave    bus
);

  localparam int               PTR_W     = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]   FILL_CNT  = (PTR_W + 1)'(FILL_LEVEL);

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    FILL     = 2'd1,
    RUN      = 2'd2
  } state_t;

  state_t stateReg, stateNext;

  logic [59:0]      fifoMem [FIFO_DEPTH];
  logic [PTR_W-1:0] wrPtrReg, rdPtrReg;
  logic [PTR_W:0]   countReg;
  logic             fifoFull, fifoEmpty;
  logic             camReady, pushAcc, popAcc, underflowHit;
  logic             underflowReg;

  logic [59:0]      s1DataReg;
  logic             s1ValidReg;
  logic             keyPix;
  logic [9:0]       camCh [3];
  logic [9:0]       bgCh  [3];
  logic [9:0]       outChReg [3];
  logic             outValidReg;

  assign fifoFull  = (countReg == DEPTH_CNT);
  assign fifoEmpty = (countReg == '0);
  // Ready comes from the registered count only, so a same-cycle pop never frees a slot early.
  assign camReady  = !fifoFull && !iRST;

  assign pushAcc      = bus.inCamValid && camReady && ((stateReg != WAIT_SOF) || bus.inCamSof);
  assign popAcc       = bus.inRequest && !fifoEmpty && (stateReg == RUN);
  assign underflowHit = bus.inRequest && fifoEmpty && (stateReg == RUN);

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      stateReg <= WAIT_SOF;
    end else begin
      stateReg <= stateNext;
    end
  end

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      WAIT_SOF: if (pushAcc) stateNext = FILL;
      FILL:     if (countReg >= FILL_CNT) stateNext = RUN;
      RUN:      stateNext = RUN;
      default:  stateNext = WAIT_SOF;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      wrPtrReg     <= '0;
      rdPtrReg     <= '0;
      countReg     <= '0;
      underflowReg <= 1'b0;
    end else begin
      if (pushAcc) wrPtrReg <= wrPtrReg + 1'b1;
      if (popAcc)  rdPtrReg <= rdPtrReg + 1'b1;
      case ({pushAcc, popAcc})
        2'b10:   countReg <= countReg + 1'b1;
        2'b01:   countReg <= countReg - 1'b1;
        default: countReg <= countReg;
      endcase
      if (underflowHit) underflowReg <= 1'b1;
    end
  end

  // Storage and read port carry no reset so they map onto block RAM; validity lives in the pointers.
  always_ff @(posedge iCLK) begin
    if (pushAcc) begin
      fifoMem[wrPtrReg] <= {bus.inCamR, bus.inCamG, bus.inCamB, bus.inBgR, bus.inBgG, bus.inBgB};
    end
  end

  always_ff @(posedge iCLK) begin
    if (popAcc) s1DataReg <= fifoMem[rdPtrReg];
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      s1ValidReg <= 1'b0;
    end else begin
      s1ValidReg <= popAcc;
    end
  end

  // Channel order 0..2 = R, G, B; camera in the upper 30 bits, background in the lower 30.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : gChannelSplit
      assign camCh[gi] = s1DataReg[59 - 10*gi -: 10];
      assign bgCh[gi]  = s1DataReg[29 - 10*gi -: 10];
    end
  endgenerate

  // Widen to 11 bits so the margin sums cannot wrap.
  assign keyPix = (camCh[1] >= KEY_G_MIN)
               && ({1'b0, camCh[1]} > ({1'b0, camCh[0]} + {1'b0, KEY_MARGIN}))
               && ({1'b0, camCh[1]} > ({1'b0, camCh[2]} + {1'b0, KEY_MARGIN}));

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : gChannelOut
`ifdef CHROMA_KEY_DEBUG_EN
      localparam logic [9:0] KEY_COLOUR = (gi == 1) ? 10'h000 : 10'h3FF;
      wire [9:0] keyCh = KEY_COLOUR;
`else
      wire [9:0] keyCh = bgCh[gi];
`endif
      always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
          outChReg[gi] <= '0;
        end else if (s1ValidReg) begin
          outChReg[gi] <= keyPix ? keyCh : camCh[gi];
        end else begin
          outChReg[gi] <= '0;
        end
      end
    end
  endgenerate

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      outValidReg <= 1'b0;
    end else begin
      outValidReg <= s1ValidReg;
    end
  end

  assign bus.outCamReady  = camReady;
  assign bus.outRed       = outChReg[0];
  assign bus.outGreen     = outChReg[1];
  assign bus.outBlue      = outChReg[2];
  assign bus.outPixValid  = outValidReg;
  assign bus.outUnderflow = underflowReg;
  assign bus.outState     = stateReg;

endmodule

// File: tb/tb_chroma_key_mixer.sv
// Randomized bench for chroma_key_mixer against a queue-based reference model of the mixer.
// Follows CHROMA_KEY_DEBUG_EN the same way the design does.
module tb_chroma_key_mixer;

  localparam int DEPTH = 16;
  localparam int FILL  = 8;

  logic iCLK = 1'b0;
  logic iRST = 1'b1;

  chroma_key_mixer_if bus ();

  chroma_key_mixer #(
    .FIFO_DEPTH(DEPTH),
    .FILL_LEVEL(FILL),
    .KEY_G_MIN (10'd400),
    .KEY_MARGIN(10'd96)
  ) dut (
    .iCLK(iCLK),
    .iRST(iRST),
    .bus (bus)
  );

  always #5 iCLK = ~iCLK;

  int checkCount = 0;
  int errorCount = 0;

  // Reference model: a plain queue of {cam, bg} beats plus the expected pixel stream.
  logic [59:0] modelQ [$];
  int          modelState;
  bit          modelUnder;
  bit          modelS1Val, modelOutVal;
  logic [29:0] modelS1Pix, modelOutPix;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [29:0] composite(input logic [59:0] beat);
    int r, g, b;
    r = int'(beat[59:50]);
    g = int'(beat[49:40]);
    b = int'(beat[39:30]);
    if (g >= 400 && g > r + 96 && g > b + 96) begin
`ifdef CHROMA_KEY_DEBUG_EN
      return {10'h3FF, 10'h000, 10'h3FF};
`else
      return beat[29:0];
`endif
    end
    return beat[59:30];
  endfunction

  task automatic modelClear();
    modelQ.delete();
    modelState  = 0;
    modelUnder  = 1'b0;
    modelS1Val  = 1'b0;
    modelOutVal = 1'b0;
    modelS1Pix  = '0;
    modelOutPix = '0;
  endtask

  task automatic checkOutputs(input string where);
    checkVal({where, ".red"},   32'(bus.outRed),       32'(modelOutPix[29:20]));
    checkVal({where, ".green"}, 32'(bus.outGreen),     32'(modelOutPix[19:10]));
    checkVal({where, ".blue"},  32'(bus.outBlue),      32'(modelOutPix[9:0]));
    checkVal({where, ".valid"}, 32'(bus.outPixValid),  32'(modelOutVal));
    checkVal({where, ".under"}, 32'(bus.outUnderflow), 32'(modelUnder));
    checkVal({where, ".state"}, 32'(bus.outState),     32'(modelState));
  endtask

  // One clock: check what is visible now, drive the next beat/request, advance the model.
  task automatic runCycle(input logic v, input logic sof, input logic req,
                          input logic [29:0] cam, input logic [29:0] bg);
    int  sz;
    bit  push, pop;
    @(negedge iCLK);
    checkOutputs("out");
    checkVal("camReady", 32'(bus.outCamReady), 32'(modelQ.size() < DEPTH));
    if (bus.outPixValid) begin
      $display("pix r=%0d g=%0d b=%0d state=%0d", bus.outRed, bus.outGreen, bus.outBlue, bus.outState);
    end

    bus.inCamValid = v;
    bus.inCamSof   = sof;
    bus.inRequest  = req;
    {bus.inCamR, bus.inCamG, bus.inCamB} = cam;
    {bus.inBgR,  bus.inBgG,  bus.inBgB}  = bg;

    sz   = modelQ.size();
    push = v && (sz < DEPTH) && (modelState != 0 || sof);
    pop  = req && (sz > 0) && (modelState == 2);
    if (req && sz == 0 && modelState == 2) modelUnder = 1'b1;
    modelOutVal = modelS1Val;
    modelOutPix = modelS1Pix;
    modelS1Val  = pop;
    modelS1Pix  = pop ? composite(modelQ[0]) : 30'd0;
    if (pop)  void'(modelQ.pop_front());
    if (push) modelQ.push_back({cam, bg});
    if (modelState == 1 && sz >= FILL)   modelState = 2;
    else if (modelState == 0 && push)    modelState = 1;
  endtask

  function automatic logic [29:0] randPix();
    logic [9:0] r, g, b;
    if ($urandom_range(0, 1) == 1) begin
      r = 10'($urandom_range(0, 400));
      g = 10'($urandom_range(350, 1023));
      b = 10'($urandom_range(0, 400));
    end else begin
      r = 10'($urandom_range(0, 1023));
      g = 10'($urandom_range(0, 1023));
      b = 10'($urandom_range(0, 1023));
    end
    return {r, g, b};
  endfunction

  task automatic randomPhase(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      runCycle($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
               $urandom_range(0, 9) < 7, randPix(), randPix());
    end
  endtask

  task automatic midReset();
    @(negedge iCLK);
    bus.inCamValid = 1'b0;
    bus.inRequest  = 1'b0;
    bus.inCamSof   = 1'b0;
    #2 iRST = 1'b1;
    #1;
    modelClear();
    checkOutputs("rst");
    checkVal("rst.camReady", 32'(bus.outCamReady), 32'd0);
    @(negedge iCLK);
    iRST = 1'b0;
  endtask

  initial begin
    bus.inCamValid = 1'b0;
    bus.inCamSof   = 1'b0;
    bus.inRequest  = 1'b0;
    {bus.inCamR, bus.inCamG, bus.inCamB} = '0;
    {bus.inBgR,  bus.inBgG,  bus.inBgB}  = '0;
    modelClear();

    repeat (3) @(negedge iCLK);
    checkOutputs("init");
    checkVal("init.camReady", 32'(bus.outCamReady), 32'd0);
    iRST = 1'b0;

    // Non-SOF beats are dropped while waiting for a frame start.
    for (int i = 0; i < 4; i++) runCycle(1'b1, 1'b0, 1'b1, randPix(), randPix());

    // SOF beat followed by the directed key / near-key pixels, requests issued before RUN.
    runCycle(1'b1, 1'b1, 1'b1, {10'd100, 10'd600, 10'd100}, {10'd5, 10'd6, 10'd7});
    runCycle(1'b1, 1'b0, 1'b1, {10'd300, 10'd390, 10'd100}, {10'd1, 10'd2, 10'd3});
    runCycle(1'b1, 1'b0, 1'b1, {10'd500, 10'd590, 10'd100}, {10'd9, 10'd9, 10'd9});
    for (int i = 0; i < 5; i++) runCycle(1'b1, 1'b0, 1'b1, randPix(), randPix());
    for (int i = 0; i < 4; i++) runCycle(1'b0, 1'b0, 1'b1, randPix(), randPix());

    // Fill to full, collide a pop with a rejected push, then drain past empty.
    for (int i = 0; i < 24; i++) runCycle(1'b1, 1'b0, 1'b0, randPix(), randPix());
    runCycle(1'b1, 1'b0, 1'b1, randPix(), randPix());
    for (int i = 0; i < 20; i++) runCycle(1'b0, 1'b0, 1'b1, randPix(), randPix());
    for (int i = 0; i < 3; i++)  runCycle(1'b0, 1'b0, 1'b0, randPix(), randPix());

    randomPhase(300);
    midReset();
    randomPhase(300);
    for (int i = 0; i < 3; i++) runCycle(1'b0, 1'b0, 1'b0, randPix(), randPix());

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
